// File: rtl/wake_up_scoreboard.sv
// wake_up_scoreboard
//
// This is a register scoreboard for an in-order issue stage. It tracks which
// architectural registers have a write pending and, for writers whose latency
// is known, counts down the cycles until the result can be bypassed. Source
// operands are reported ready as soon as their producer can forward.
//
// Optional feature: define WAKEUP_WB_BYPASS_EN to make a source that matches
// the current write-back register ready in that same cycle. When the macro is
// undefined, the source becomes ready on the cycle after the write-back.
//
// Parameters:
//   NUM_SRC   source-operand ports checked per cycle
//   NUM_REGS  architectural register count (AW = clog2(NUM_REGS))
//   LAT_W     width of the per-register latency countdown
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   issue_valid  an instruction is offered for issue
//   issue_we     the offered instruction writes issue_rd
//   issue_rd     destination register
//   issue_lat    cycles until the result is bypassable; 0 means unknown latency
//   issue_ready  the offered instruction is accepted this cycle
//   src_valid    per-source flag, set when the operand comes from the register file
//   src_addr     per-source register number; source i is [i*AW +: AW]
//   src_ready    per-source operand-available flag (combinational)
//   wb_valid     a register write-back occurs this cycle
//   wb_rd        write-back register number
//   flush        discards every pending write
//   busy_count   registered popcount of the busy registers
module wake_up_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                issue_valid,
  input  logic                                issue_we,
  input  logic [$clog2(NUM_REGS)-1:0]         issue_rd,
  input  logic [LAT_W-1:0]                    issue_lat,
  output logic                                issue_ready,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0] src_addr,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic                                wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]         wb_rd,
  input  logic                                flush,
  output logic [$clog2(NUM_REGS):0]           busy_count
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0]            known_q, known_d;
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [AW:0]                    count_d;
  logic                           issue_fire;
  logic [AW-1:0]                  src_reg;
  logic                           wb_hit;

  // A WAW against an unknown-latency writer must stall, because there is no
  // way to tell which of the two writes would land last.
  assign issue_ready = !flush && !(issue_we && busy_q[issue_rd] && !known_q[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && issue_we && (issue_rd != '0);

  // Next-state logic. The steps are applied in order of increasing priority:
  // countdown, then write-back clear, then issue load, then flush.
  always_comb begin
    busy_d  = busy_q;
    known_d = known_q;
    cnt_d   = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (busy_q[r] && known_q[r] && (cnt_q[r] != '0))
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
    end
    if (wb_valid) begin
      busy_d[wb_rd]  = 1'b0;
      known_d[wb_rd] = 1'b0;
      cnt_d[wb_rd]   = '0;
    end
    // When an issue and a write-back hit the same register, the issue wins.
    // That register belongs to the new writer.
    if (issue_fire) begin
      busy_d[issue_rd]  = 1'b1;
      known_d[issue_rd] = (issue_lat != '0);
      cnt_d[issue_rd]   = issue_lat;
    end
    if (flush) begin
      busy_d  = '0;
      known_d = '0;
      cnt_d   = '0;
    end
    busy_d[0]  = 1'b0;
    known_d[0] = 1'b0;
    cnt_d[0]   = '0;
  end

  // The count is taken from the next busy vector so that the registered value
  // always matches the busy bits after the same edge.
  always_comb begin
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      count_d = count_d + (AW+1)'(busy_d[r]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      known_q    <= '0;
      cnt_q      <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_d;
      known_q    <= known_d;
      cnt_q      <= cnt_d;
      busy_count <= count_d;
    end
  end

  // Sources are evaluated against the state before this cycle's issue.
  // A same-cycle issue therefore never blocks a source.
  always_comb begin
    src_ready = '0;
    src_reg   = '0;
    wb_hit    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_reg = src_addr[i*AW +: AW];
`ifdef WAKEUP_WB_BYPASS_EN
      wb_hit  = wb_valid && (wb_rd == src_reg);
`else
      wb_hit  = 1'b0;
`endif
      src_ready[i] = !src_valid[i] || (src_reg == '0) || !busy_q[src_reg] ||
                     (known_q[src_reg] && (cnt_q[src_reg] == '0)) || wb_hit;
    end
  end

endmodule
